// File: rtl/arm_data_bridge_pkg.sv
// Shared widths and FSM encodings for the ARM <-> RSA wrapper data bridge.
package arm_data_bridge_pkg;

  localparam int unsigned WORD_W  = 32;
  localparam int unsigned WORDS   = 32;
  localparam int unsigned BLOCK_W = WORD_W * WORDS;
  localparam int unsigned IDX_W   = $clog2(WORDS);

  typedef enum logic {
    IN_FILL = 1'b0,
    IN_FULL = 1'b1
  } in_state_e;

  typedef enum logic {
    OUT_IDLE = 1'b0,
    OUT_SEND = 1'b1
  } out_state_e;

endpackage

// File: rtl/arm_data_bridge_word_serializer.sv
// Egress path: captures one result block and shifts it out one word per handshake,
// lowest word first.
module word_serializer
  import arm_data_bridge_pkg::*;
#(
  parameter int unsigned WORD_W = arm_data_bridge_pkg::WORD_W,
  parameter int unsigned WORDS  = arm_data_bridge_pkg::WORDS
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [WORD_W*WORDS-1:0]    block,
  input  logic                       block_valid,
  output logic                       block_ready,
  output logic [WORD_W-1:0]          word,
  output logic                       word_valid,
  input  logic                       word_ready,
  output logic                       send_next_c
);

  localparam int unsigned BLOCK_W = WORD_W * WORDS;
  localparam int unsigned IDX_W   = $clog2(WORDS);

  out_state_e         state_q, state_d;
  logic [BLOCK_W-1:0] shreg_q, shreg_d;
  logic [IDX_W-1:0]   cnt_q, cnt_d;
  logic               block_ready_d;
  logic               word_valid_d;
  logic [WORD_W-1:0]  word_d;

  // State and registered outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= OUT_IDLE;
      shreg_q     <= '0;
      cnt_q       <= '0;
      block_ready <= 1'b1;
      word_valid  <= 1'b0;
      word        <= '0;
    end else begin
      state_q     <= state_d;
      shreg_q     <= shreg_d;
      cnt_q       <= cnt_d;
      block_ready <= block_ready_d;
      word_valid  <= word_valid_d;
      word        <= word_d;
    end
  end

  // Next state; outputs derive from the next state so they line up with it
  always_comb begin
    state_d = state_q;
    shreg_d = shreg_q;
    cnt_d   = cnt_q;
    case (state_q)
      OUT_IDLE: begin
        if (block_valid) begin
          shreg_d = block;
          cnt_d   = '0;
          state_d = OUT_SEND;
        end
      end
      OUT_SEND: begin
        if (word_ready) begin
          shreg_d = shreg_q >> WORD_W;
          cnt_d   = cnt_q + IDX_W'(1);
          if (cnt_q == IDX_W'(WORDS - 1)) begin
            state_d = OUT_IDLE;
          end
        end
      end
      default: state_d = OUT_IDLE;
    endcase
    block_ready_d = (state_d == OUT_IDLE);
    word_valid_d  = (state_d == OUT_SEND);
    word_d        = shreg_d[WORD_W-1:0];
  end

  assign send_next_c = (state_d == OUT_SEND);

endmodule

// File: rtl/arm_data_bridge.sv
// ARM-side word bus to RSA wrapper block bridge: ingress assembles WORDS words into
// one operand block, egress serialises a result block back into words.
module arm_data_bridge
  import arm_data_bridge_pkg::*;
#(
  parameter int unsigned WORD_W = arm_data_bridge_pkg::WORD_W,
  parameter int unsigned WORDS  = arm_data_bridge_pkg::WORDS
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [WORD_W-1:0]          s_word,
  input  logic                       s_word_valid,
  output logic                       s_word_ready,
  output logic [WORD_W*WORDS-1:0]    arm_to_fpga_data,
  output logic                       arm_to_fpga_data_valid,
  input  logic                       arm_to_fpga_data_ready,
  input  logic [WORD_W*WORDS-1:0]    fpga_to_arm_data,
  input  logic                       fpga_to_arm_data_valid,
  output logic                       fpga_to_arm_data_ready,
  output logic [WORD_W-1:0]          m_word,
  output logic                       m_word_valid,
  input  logic                       m_word_ready,
  output logic                       busy
);

  localparam int unsigned BLOCK_W = WORD_W * WORDS;
  localparam int unsigned IDX_W   = $clog2(WORDS);

  in_state_e          in_state_q, in_state_d;
  logic [IDX_W-1:0]   in_idx_q, in_idx_d;
  logic [BLOCK_W-1:0] in_data_d;
  logic               s_word_ready_d;
  logic               arm_valid_d;
  logic               busy_d;
  logic               out_send_next_c;

  // Ingress state and registered outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      in_state_q             <= IN_FILL;
      in_idx_q               <= '0;
      arm_to_fpga_data       <= '0;
      s_word_ready           <= 1'b1;
      arm_to_fpga_data_valid <= 1'b0;
      busy                   <= 1'b0;
    end else begin
      in_state_q             <= in_state_d;
      in_idx_q               <= in_idx_d;
      arm_to_fpga_data       <= in_data_d;
      s_word_ready           <= s_word_ready_d;
      arm_to_fpga_data_valid <= arm_valid_d;
      busy                   <= busy_d;
    end
  end

  // Word k of the block lands at bits [WORD_W*k +: WORD_W]; the block is frozen while full
  always_comb begin
    in_state_d = in_state_q;
    in_idx_d   = in_idx_q;
    in_data_d  = arm_to_fpga_data;
    case (in_state_q)
      IN_FILL: begin
        if (s_word_valid) begin
          for (int unsigned k = 0; k < WORDS; k++) begin
            if (in_idx_q == IDX_W'(k)) begin
              in_data_d[k*WORD_W +: WORD_W] = s_word;
            end
          end
          in_idx_d = in_idx_q + IDX_W'(1);
          if (in_idx_q == IDX_W'(WORDS - 1)) begin
            in_state_d = IN_FULL;
          end
        end
      end
      IN_FULL: begin
        if (arm_to_fpga_data_ready) begin
          in_state_d = IN_FILL;
        end
      end
      default: in_state_d = IN_FILL;
    endcase
    s_word_ready_d = (in_state_d == IN_FILL);
    arm_valid_d    = (in_state_d == IN_FULL);
    busy_d         = (in_idx_d != '0) || (in_state_d == IN_FULL) || out_send_next_c;
  end

  word_serializer #(
    .WORD_W (WORD_W),
    .WORDS  (WORDS)
  ) u_word_serializer (
    .clk         (clk),
    .reset       (reset),
    .block       (fpga_to_arm_data),
    .block_valid (fpga_to_arm_data_valid),
    .block_ready (fpga_to_arm_data_ready),
    .word        (m_word),
    .word_valid  (m_word_valid),
    .word_ready  (m_word_ready),
    .send_next_c (out_send_next_c)
  );

endmodule

// File: tb/tb_arm_data_bridge.sv
// Self-checking bench for arm_data_bridge: directed scenarios plus a randomized
// concurrent run, all checked every cycle against a transaction-level model.
module tb_arm_data_bridge;

  localparam int unsigned W  = 32;
  localparam int unsigned N  = 32;
  localparam int unsigned BW = W * N;

  logic          clk = 1'b0;
  logic          reset;
  logic [W-1:0]  s_word;
  logic          s_word_valid;
  logic          s_word_ready;
  logic [BW-1:0] arm_to_fpga_data;
  logic          arm_to_fpga_data_valid;
  logic          arm_to_fpga_data_ready;
  logic [BW-1:0] fpga_to_arm_data;
  logic          fpga_to_arm_data_valid;
  logic          fpga_to_arm_data_ready;
  logic [W-1:0]  m_word;
  logic          m_word_valid;
  logic          m_word_ready;
  logic          busy;

  always #5 clk = ~clk;

  arm_data_bridge #(.WORD_W(W), .WORDS(N)) dut (
    .clk                    (clk),
    .reset                  (reset),
    .s_word                 (s_word),
    .s_word_valid           (s_word_valid),
    .s_word_ready           (s_word_ready),
    .arm_to_fpga_data       (arm_to_fpga_data),
    .arm_to_fpga_data_valid (arm_to_fpga_data_valid),
    .arm_to_fpga_data_ready (arm_to_fpga_data_ready),
    .fpga_to_arm_data       (fpga_to_arm_data),
    .fpga_to_arm_data_valid (fpga_to_arm_data_valid),
    .fpga_to_arm_data_ready (fpga_to_arm_data_ready),
    .m_word                 (m_word),
    .m_word_valid           (m_word_valid),
    .m_word_ready           (m_word_ready),
    .busy                   (busy)
  );

  int vectors     = 0;
  int miscompares = 0;

  task automatic chk(input string name, input logic [W-1:0] got, input logic [W-1:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, got, exp);
    end
  endtask

  task automatic chk_blk(input string name, input logic [BW-1:0] got, input logic [BW-1:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      for (int k = 0; k < N; k++) begin
        if (got[k*W +: W] !== exp[k*W +: W]) begin
          $display("FAIL %s at %0t: word %0d got %0h expected %0h",
                   name, $time, k, got[k*W +: W], exp[k*W +: W]);
          break;
        end
      end
    end
  endtask

  // Reference model: an array being filled, a "full" flag, and a queue of pending egress words
  logic [W-1:0] mdl_blk [N];
  int           mdl_cnt  = 0;
  bit           mdl_full = 0;
  logic [W-1:0] mdl_q [$];
  bit           mdl_ok   = 0;

  initial begin
    forever begin
      @(posedge clk);
      if (reset) begin
        mdl_cnt  = 0;
        mdl_full = 0;
        for (int k = 0; k < N; k++) mdl_blk[k] = '0;
        mdl_q.delete();
        mdl_ok = 1;
      end else begin
        if (!mdl_full) begin
          if (s_word_valid) begin
            mdl_blk[mdl_cnt] = s_word;
            mdl_cnt++;
            if (mdl_cnt == N) begin
              mdl_cnt  = 0;
              mdl_full = 1;
            end
          end
        end else if (arm_to_fpga_data_ready) begin
          mdl_full = 0;
        end
        if (mdl_q.size() == 0) begin
          if (fpga_to_arm_data_valid)
            for (int k = 0; k < N; k++) mdl_q.push_back(fpga_to_arm_data[k*W +: W]);
        end else if (m_word_ready) begin
          void'(mdl_q.pop_front());
        end
      end
    end
  end

  // Every-cycle comparison of all DUT outputs against the model
  initial begin
    logic [BW-1:0] exp_blk;
    forever begin
      @(negedge clk);
      if (mdl_ok) begin
        for (int k = 0; k < N; k++) exp_blk[k*W +: W] = mdl_blk[k];
        chk("s_word_ready", W'(s_word_ready), W'(!mdl_full));
        chk("arm_valid", W'(arm_to_fpga_data_valid), W'(mdl_full));
        chk_blk("arm_data", arm_to_fpga_data, exp_blk);
        chk("fpga_ready", W'(fpga_to_arm_data_ready), W'(mdl_q.size() == 0));
        chk("m_word_valid", W'(m_word_valid), W'(mdl_q.size() != 0));
        if (mdl_q.size() != 0) chk("m_word", m_word, mdl_q[0]);
        chk("busy", W'(busy), W'((mdl_cnt != 0) || mdl_full || (mdl_q.size() != 0)));
      end
    end
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    s_word                 = '0;
    s_word_valid           = 1'b0;
    arm_to_fpga_data_ready = 1'b0;
    fpga_to_arm_data       = '0;
    fpga_to_arm_data_valid = 1'b0;
    m_word_ready           = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
  endtask

  task automatic send_word(input logic [W-1:0] w);
    int n = 0;
    s_word       = w;
    s_word_valid = 1'b1;
    while (!s_word_ready && n < 100) begin
      tick();
      n++;
    end
    chk("send_ready", W'(s_word_ready), W'(1));
    tick();
    s_word_valid = 1'b0;
  endtask

  initial begin
    logic [W-1:0] got [$];
    logic [W-1:0] fresh [N];
    bit           r;
    int           n;

    reset = 1'b1;
    idle_inputs();
    tick();
    tick();
    reset = 1'b0;

    // Reset values
    chk("rst_s_ready", W'(s_word_ready), W'(1));
    chk("rst_arm_valid", W'(arm_to_fpga_data_valid), W'(0));
    chk("rst_fpga_ready", W'(fpga_to_arm_data_ready), W'(1));
    chk("rst_m_valid", W'(m_word_valid), W'(0));
    chk("rst_busy", W'(busy), W'(0));
    chk("rst_m_word", m_word, 32'h0);
    chk("rst_arm_data", W'(arm_to_fpga_data == '0), W'(1));

    // Back-to-back words k = k; valid one cycle after the last word
    for (int k = 0; k < N; k++) begin
      s_word       = W'(k);
      s_word_valid = 1'b1;
      tick();
      if (k == N - 2) chk("pre_full_valid", W'(arm_to_fpga_data_valid), W'(0));
    end
    s_word = 32'h0000_0033;
    chk("full_valid", W'(arm_to_fpga_data_valid), W'(1));
    chk("full_s_ready", W'(s_word_ready), W'(0));
    chk("full_word0", arm_to_fpga_data[0 +: W], 32'h0);
    chk("full_word5", arm_to_fpga_data[5*W +: W], 32'h5);
    chk("full_word31", arm_to_fpga_data[31*W +: W], 32'h1F);

    // Hold ready low 10 cycles with a 33rd word pending
    for (int c = 0; c < 10; c++) tick();
    chk("stall_s_ready", W'(s_word_ready), W'(0));
    chk("stall_valid", W'(arm_to_fpga_data_valid), W'(1));
    chk("stall_word31", arm_to_fpga_data[31*W +: W], 32'h1F);
    arm_to_fpga_data_ready = 1'b1;
    tick();
    arm_to_fpga_data_ready = 1'b0;
    chk("post_hs_valid", W'(arm_to_fpga_data_valid), W'(0));
    chk("post_hs_s_ready", W'(s_word_ready), W'(1));
    tick();
    s_word_valid = 1'b0;
    chk("word33_kept", arm_to_fpga_data[0 +: W], 32'h33);
    chk("word33_busy", W'(busy), W'(1));

    // Reset after 17 words, then a fresh block
    do_reset();
    for (int k = 0; k < 17; k++) send_word(W'($urandom));
    do_reset();
    for (int k = 0; k < N; k++) begin
      fresh[k] = W'($urandom);
      send_word(fresh[k]);
    end
    for (int k = 0; k < N; k++) chk("fresh_word", arm_to_fpga_data[k*W +: W], fresh[k]);
    arm_to_fpga_data_ready = 1'b1;
    tick();
    arm_to_fpga_data_ready = 1'b0;

    // Egress block 0xA5A50000+k with m_word_ready toggling
    for (int k = 0; k < N; k++) fpga_to_arm_data[k*W +: W] = W'(32'hA5A5_0000 + k);
    fpga_to_arm_data_valid = 1'b1;
    tick();
    fpga_to_arm_data_valid = 1'b0;
    r = 1'b1;
    n = 0;
    while (got.size() < N && n < 300) begin
      m_word_ready = r;
      if (m_word_valid && r) got.push_back(m_word);
      tick();
      r = !r;
      n++;
    end
    m_word_ready = 1'b0;
    chk("egress_count", W'(got.size()), W'(N));
    for (int k = 0; k < N; k++) chk("egress_word", got[k], W'(32'hA5A5_0000 + k));
    chk("egress_idle_busy", W'(busy), W'(0));

    // Concurrent random traffic on both directions, one reset in the middle
    for (int c = 0; c < 3000; c++) begin
      reset                  = (c == 1500);
      s_word_valid           = ($urandom % 4) != 0;
      s_word                 = W'($urandom);
      arm_to_fpga_data_ready = ($urandom % 3) == 0;
      fpga_to_arm_data_valid = ($urandom % 8) == 0;
      for (int k = 0; k < N; k++) fpga_to_arm_data[k*W +: W] = W'($urandom);
      m_word_ready           = ($urandom % 2) == 0;
      tick();
    end
    reset = 1'b0;

    // Finish any partial ingress block and drain both sides; busy must then fall
    fpga_to_arm_data_valid = 1'b0;
    arm_to_fpga_data_ready = 1'b1;
    m_word_ready           = 1'b1;
    n = 0;
    while (busy && n < 400) begin
      s_word_valid = (mdl_cnt != 0);
      s_word       = W'($urandom);
      tick();
      n++;
    end
    s_word_valid = 1'b0;
    chk("drain_busy", W'(busy), W'(0));
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
